// File: rtl/crc_stream_engine.sv
// crc_stream_engine: frame-aware CRC engine on a valid/ready word stream.
//
// Generate mode (mode=0) forwards the payload and appends the CRC word.
// Check mode (mode=1) forwards the frame unchanged and compares its trailing
// word against the CRC of the preceding words.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mode                 0 = generate, 1 = check (sampled on a frame's first word)
//   s_data/s_valid/
//   s_last/s_ready       input stream
//   m_data/m_valid/
//   m_last/m_ready       output stream (one register stage)
//   crc_value            final CRC (after XOROUT) of the most recent frame
//   crc_done             one-cycle pulse at frame completion
//   crc_err              check-mode mismatch, valid while crc_done=1
//   err_cnt              saturating count of check-mode mismatches
//   err_clr              synchronous clear of err_cnt (wins over increment)
module crc_stream_engine #(
  parameter int              CRC_W    = 16,
  parameter int              DATA_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h5089,
  parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
  parameter logic [CRC_W-1:0] XOROUT  = 16'h0000,
  parameter int              ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic [CRC_W-1:0]    crc_value,
  output logic                crc_done,
  output logic                crc_err,
  output logic [ERRCNT_W-1:0] err_cnt,
  input  logic                err_clr
);

  typedef enum logic [1:0] {IDLE, ACCUM, APPEND, DONE} state_t;

  state_t            state_q, state_next;
  logic [CRC_W-1:0]  crc_q;
  logic              mode_q;
  logic              mismatch_q;

  logic              out_free;
  logic              accept;
  logic              mode_eff;
  logic              covered;
  logic              append_load;
  logic [CRC_W-1:0]  crc_upd;
  logic [CRC_W-1:0]  crc_fin;
  logic              crc_match;

  // MSB-first bit-serial update, unrolled into one cycle.
  function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  assign out_free    = !m_valid || m_ready;
  assign accept      = s_valid && s_ready;
  // The first word of a frame sees the live mode input; later words use the
  // latched copy so a mode change mid-frame has no effect.
  assign mode_eff    = (state_q == IDLE) ? mode : mode_q;
  // In check mode the trailing word is the CRC itself and is not covered.
  assign covered     = !mode_eff || !s_last;
  assign append_load = (state_q == APPEND) && out_free;
  assign crc_upd     = crc_next(crc_q, s_data);
  assign crc_fin     = crc_q ^ XOROUT;
  assign crc_match   = (crc_fin == s_data[CRC_W-1:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (!s_last)       state_next = ACCUM;
          else if (mode_eff) state_next = DONE;
          else               state_next = APPEND;
        end
      end
      APPEND:  if (out_free) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    s_ready  = ((state_q == IDLE) || (state_q == ACCUM)) && out_free;
    crc_done = (state_q == DONE);
    crc_err  = (state_q == DONE) && mismatch_q;
  end

  // CRC register, mode latch and frame result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q      <= INIT;
      mode_q     <= 1'b0;
      mismatch_q <= 1'b0;
      crc_value  <= '0;
    end else begin
      if (state_q == DONE)         crc_q <= INIT;
      else if (accept && covered)  crc_q <= crc_upd;

      if (accept && (state_q == IDLE)) mode_q <= mode;

      // Result is captured on the way into DONE so it is visible with crc_done.
      if (accept && s_last && mode_eff) begin
        crc_value  <= crc_fin;
        mismatch_q <= !crc_match;
      end else if (append_load) begin
        crc_value  <= crc_fin;
        mismatch_q <= 1'b0;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (accept) begin
      m_data  <= s_data;
      m_last  <= mode_eff && s_last;
      m_valid <= 1'b1;
    end else if (append_load) begin
      m_data  <= DATA_W'(crc_fin);
      m_last  <= 1'b1;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Saturating mismatch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       err_cnt <= '0;
    else if (err_clr)                                 err_cnt <= '0;
    else if (crc_err && (err_cnt != {ERRCNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: directed bench for crc_stream_engine.
// dut0 uses INIT=0, dut1 the default INIT=16'hFFFF; both share the input
// stream and 'sel' picks which one is observed.
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        m_ready;
  logic        m_ready_base;
  logic        tog;
  logic        toggle_en;
  logic        err_clr;
  logic        sel;

  logic        s_ready0, s_ready1, m_valid0, m_valid1, m_last0, m_last1;
  logic        crc_done0, crc_done1, crc_err0, crc_err1;
  logic [15:0] m_data0, m_data1, crc_value0, crc_value1, err_cnt0, err_cnt1;

  logic        s_ready_s, m_valid_s, m_last_s, crc_done_s, crc_err_s;
  logic [15:0] m_data_s, crc_value_s;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          done_cnt = 0;
  int          app_viol = 0;
  logic        in_append = 1'b0;
  logic [15:0] last_val;
  logic        last_err;
  logic [15:0] oq_d[$];
  logic        oq_l[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (toggle_en) tog = ~tog;
  end
  assign m_ready = toggle_en ? tog : m_ready_base;

  crc_stream_engine #(.INIT(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready0), .m_data(m_data0), .m_valid(m_valid0),
    .m_last(m_last0), .m_ready(m_ready), .crc_value(crc_value0),
    .crc_done(crc_done0), .crc_err(crc_err0), .err_cnt(err_cnt0), .err_clr(err_clr)
  );

  crc_stream_engine dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready1), .m_data(m_data1), .m_valid(m_valid1),
    .m_last(m_last1), .m_ready(m_ready), .crc_value(crc_value1),
    .crc_done(crc_done1), .crc_err(crc_err1), .err_cnt(err_cnt1), .err_clr(err_clr)
  );

  assign s_ready_s   = sel ? s_ready1   : s_ready0;
  assign m_valid_s   = sel ? m_valid1   : m_valid0;
  assign m_last_s    = sel ? m_last1    : m_last0;
  assign m_data_s    = sel ? m_data1    : m_data0;
  assign crc_done_s  = sel ? crc_done1  : crc_done0;
  assign crc_err_s   = sel ? crc_err1   : crc_err0;
  assign crc_value_s = sel ? crc_value1 : crc_value0;

  // Monitor: records output words and frame results, and checks that no
  // input is offered between the last generate word and frame completion.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_append && s_ready_s) app_viol++;
      if (crc_done_s) begin
        done_cnt++;
        last_val  = crc_value_s;
        last_err  = crc_err_s;
        in_append = 1'b0;
      end
      if (m_valid_s && m_ready) begin
        oq_d.push_back(m_data_s);
        oq_l.push_back(m_last_s);
      end
      if (s_valid && s_ready_s && s_last && !mode) in_append = 1'b1;
    end
  end

  function automatic logic [15:0] model_crc(input logic [15:0] init, input logic [15:0] w[$]);
    logic [15:0] c;
    logic        fb;
    c = init;
    foreach (w[k]) begin
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ w[k][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h5089 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send(input logic [15:0] d, input logic l, input logic md);
    s_data  = d;
    s_last  = l;
    mode    = md;
    s_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (s_ready_s) begin
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (done_cnt >= target) begin
        #1;
        return;
      end
    end
    #1;
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_q();
    oq_d.delete();
    oq_l.delete();
  endtask

  initial begin
    logic [15:0] w[$];
    logic [15:0] gen_crc;
    int          base;

    rst_n = 1'b0; mode = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    m_ready_base = 1'b1; tog = 1'b0; toggle_en = 1'b0; err_clr = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid",   32'(m_valid0),   32'd0);
    check("rst_m_data",    32'(m_data0),    32'd0);
    check("rst_m_last",    32'(m_last0),    32'd0);
    check("rst_crc_value", 32'(crc_value0), 32'd0);
    check("rst_crc_done",  32'(crc_done0),  32'd0);
    check("rst_crc_err",   32'(crc_err0),   32'd0);
    check("rst_err_cnt",   32'(err_cnt0),   32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Generate, single word 0x0001, INIT=0 -> CRC 0x5089
    clear_q();
    base = done_cnt;
    send(16'h0001, 1'b1, 1'b0);
    wait_done(base + 1);
    repeat (2) @(posedge clk);
    #1;
    check("gen1_crc_value", 32'(last_val), 32'h5089);
    check("gen1_crc_err",   32'(last_err), 32'd0);
    check("gen1_words",     32'(oq_d.size()), 32'd2);
    if (oq_d.size() == 2) begin
      check("gen1_w0",    32'(oq_d[0]), 32'h0001);
      check("gen1_last0", 32'(oq_l[0]), 32'd0);
      check("gen1_w1",    32'(oq_d[1]), 32'h5089);
      check("gen1_last1", 32'(oq_l[1]), 32'd1);
    end

    // Check, good frame {0x0001, 0x5089}
    clear_q();
    base = done_cnt;
    send(16'h0001, 1'b0, 1'b1);
    send(16'h5089, 1'b1, 1'b1);
    wait_done(base + 1);
    repeat (2) @(posedge clk);
    #1;
    check("chk_ok_err",   32'(last_err), 32'd0);
    check("chk_ok_value", 32'(last_val), 32'h5089);
    check("chk_ok_words", 32'(oq_d.size()), 32'd2);
    if (oq_d.size() == 2) begin
      check("chk_ok_last0", 32'(oq_l[0]), 32'd0);
      check("chk_ok_w1",    32'(oq_d[1]), 32'h5089);
      check("chk_ok_last1", 32'(oq_l[1]), 32'd1);
    end
    check("chk_ok_errcnt", 32'(err_cnt0), 32'd0);

    // Check, corrupted CRC word -> mismatch, counter increments, then clear
    base = done_cnt;
    send(16'h0001, 1'b0, 1'b1);
    send(16'h5088, 1'b1, 1'b1);
    wait_done(base + 1);
    repeat (2) @(posedge clk);
    #1;
    check("chk_bad_err",    32'(last_err), 32'd1);
    check("chk_bad_errcnt", 32'(err_cnt0), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clr", 32'(err_cnt0), 32'd0);

    // Single-word check frame: compared against INIT^XOROUT = 0
    clear_q();
    base = done_cnt;
    send(16'h0000, 1'b1, 1'b1);
    wait_done(base + 1);
    repeat (2) @(posedge clk);
    #1;
    check("chk1w_err",  32'(last_err), 32'd0);
    check("chk1w_last", (oq_l.size() == 1) ? 32'(oq_l[0]) : 32'hFFFF_FFFF, 32'd1);
    check("chk1w_errcnt", 32'(err_cnt0), 32'd0);

    // Generate, 4 random words with m_ready toggling every cycle
    clear_q();
    w.delete();
    for (int k = 0; k < 4; k++) w.push_back(16'($urandom));
    app_viol  = 0;
    toggle_en = 1'b1;
    base = done_cnt;
    for (int k = 0; k < 4; k++) send(w[k], (k == 3), 1'b0);
    wait_done(base + 1);
    toggle_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rnd_words", 32'(oq_d.size()), 32'd5);
    if (oq_d.size() == 5) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rnd_w%0d", k),    32'(oq_d[k]), 32'(w[k]));
        check($sformatf("rnd_last%0d", k), 32'(oq_l[k]), 32'd0);
      end
      check("rnd_crc_word", 32'(oq_d[4]), 32'(model_crc(16'h0000, w)));
      check("rnd_crc_last", 32'(oq_l[4]), 32'd1);
    end
    check("rnd_crc_value", 32'(last_val), 32'(model_crc(16'h0000, w)));
    check("rnd_append_ready", 32'(app_viol), 32'd0);

    // Default INIT=0xFFFF: generate, then feed the frame back in check mode
    sel = 1'b1;
    clear_q();
    w.delete();
    w.push_back(16'h1234);
    w.push_back(16'hABCD);
    base = done_cnt;
    send(16'h1234, 1'b0, 1'b0);
    send(16'hABCD, 1'b1, 1'b0);
    wait_done(base + 1);
    repeat (2) @(posedge clk);
    #1;
    gen_crc = last_val;
    check("ffff_gen_value", 32'(gen_crc), 32'(model_crc(16'hFFFF, w)));
    check("ffff_gen_word", (oq_d.size() == 3) ? 32'(oq_d[2]) : 32'hFFFF_FFFF,
          32'(model_crc(16'hFFFF, w)));
    base = done_cnt;
    send(16'h1234, 1'b0, 1'b1);
    send(16'hABCD, 1'b0, 1'b1);
    send(gen_crc,  1'b1, 1'b1);
    wait_done(base + 1);
    #1;
    check("ffff_chk_err",   32'(last_err), 32'd0);
    check("ffff_chk_value", 32'(last_val), 32'(gen_crc));
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame: outputs drop immediately, no crc_done
    send(16'h1111, 1'b0, 1'b0);
    send(16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    base  = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid0), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt), 32'(base));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = done_cnt;
    send(16'h0001, 1'b1, 1'b0);
    wait_done(base + 1);
    check("postrst_crc_value", 32'(last_val), 32'h5089);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
